// File: rtl/lif_engine_pkg.sv
// rtl/lif_engine_pkg.sv - LIF engine types, constants and fp32 add/compare helpers
package lif_engine_pkg;

  typedef enum logic [1:0] {ACCUM, SCAN, EMIT, DONE} lif_state_e;

  localparam logic [31:0] FP_ZERO         = 32'h0000_0000;
  localparam logic [31:0] LIF_DEFAULT_VTH = 32'h4237_851f;

  // Round-to-nearest-even fp32 add; NaN/Inf propagate without flags.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, res;
    logic [7:0]  ex, ey, d;
    logic [26:0] mx, my, m;
    logic [27:0] s;
    logic [24:0] r;
    logic [9:0]  e;
    logic        sticky;
    res = FP_ZERO;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
      if (a[30:23] == 8'hff && a[22:0] != 23'd0) res = a;
      else if (b[30:23] == 8'hff && b[22:0] != 23'd0) res = b;
      else if (a[30:23] == 8'hff && b[30:23] == 8'hff && a[31] != b[31]) res = 32'h7fc0_0000;
      else if (a[30:23] == 8'hff) res = a;
      else res = b;
    end else begin
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      ex = (x[30:23] == 8'h00) ? 8'd1 : x[30:23];
      ey = (y[30:23] == 8'h00) ? 8'd1 : y[30:23];
      mx = {x[30:23] != 8'h00, x[22:0], 3'b000};
      my = {y[30:23] != 8'h00, y[22:0], 3'b000};
      d  = ex - ey;
      sticky = 1'b0;
      for (int k = 0; k < 27; k++) begin
        if (k < int'(d)) begin
          sticky = sticky | my[0];
          my     = my >> 1;
        end
      end
      my[0] = my[0] | sticky;
      e = {2'b00, ex};
      if (x[31] == y[31]) begin
        s = {1'b0, mx} + {1'b0, my};
        if (s[27]) begin
          m = {s[27:2], s[1] | s[0]};
          e = e + 10'd1;
        end else begin
          m = s[26:0];
        end
      end else begin
        m = mx - my;
        for (int k = 0; k < 26; k++) begin
          if (!m[26] && e > 10'd1) begin
            m = m << 1;
            e = e - 10'd1;
          end
        end
      end
      r = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
      if (r[24]) begin
        r = r >> 1;
        e = e + 10'd1;
      end
      if (r == 25'd0) res = {x[31] & y[31], 31'd0};
      else if (e >= 10'd255) res = {x[31], 8'hff, 23'd0};
      else res = {x[31], r[23] ? e[7:0] : 8'h00, r[22:0]};
    end
    return res;
  endfunction

  // Strict a > b; any NaN compares false and +0 equals -0.
  function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
    logic res;
    if ((a[30:23] == 8'hff && a[22:0] != 23'd0) || (b[30:23] == 8'hff && b[22:0] != 23'd0))
      res = 1'b0;
    else if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
      res = 1'b0;
    else if (a[31] != b[31])
      res = b[31];
    else if (!a[31])
      res = a[30:0] > b[30:0];
    else
      res = a[30:0] < b[30:0];
    return res;
  endfunction

endpackage

// File: rtl/lif_fp_update.sv
// rtl/lif_fp_update.sv - combinational fp32 accumulate adder, reset subtractor and threshold comparator
module lif_fp_update
  import lif_engine_pkg::*;
(
  input  logic [31:0] acc_v,
  input  logic [31:0] acc_w,
  input  logic [31:0] scan_v,
  input  logic [31:0] scan_vth,
  output logic [31:0] acc_sum,
  output logic [31:0] scan_diff,
  output logic        scan_gt
);

  assign acc_sum   = fp_add(acc_v, acc_w);
  assign scan_diff = fp_add(scan_v, {~scan_vth[31], scan_vth[30:0]});
  assign scan_gt   = fp_gt(scan_v, scan_vth);

endmodule

// File: rtl/lif_neuron_array_engine.sv
// rtl/lif_neuron_array_engine.sv - time-multiplexed fp32 LIF neuron array with spike sweep
// Optional feature: define LIF_REFRACTORY_EN for per-neuron refractory counters.
module lif_neuron_array_engine
  import lif_engine_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int ID_W        = 4,
  parameter int RESET_MODE  = 0,
  parameter int REFRACT_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ID_W-1:0]      in_id,
  input  logic [31:0]          in_weight,
  input  logic                 timestep_end,
  input  logic [31:0]          v_threshold,
  input  logic [REFRACT_W-1:0] refract_len,
  output logic                 spike_valid,
  input  logic                 spike_ready,
  output logic [ID_W-1:0]      spike_id,
  output logic                 busy,
  output logic                 done
);

  lif_state_e      state, state_next;
  logic [ID_W-1:0] idx;
  logic [31:0]     v_mem [NUM_NEURONS];
  logic [31:0]     vth_r;
  logic [31:0]     acc_sum, scan_diff;
  logic            scan_gt, id_ok, weight_ok, scan_eligible, accept, last_idx, fire;

  assign id_ok    = int'(in_id) < NUM_NEURONS;
  assign accept   = (state == ACCUM) && in_valid;
  assign last_idx = int'(idx) == NUM_NEURONS - 1;
  assign fire     = (state == SCAN) && scan_eligible && scan_gt;

`ifdef LIF_REFRACTORY_EN
  logic [REFRACT_W-1:0] refr [NUM_NEURONS];

  assign weight_ok     = id_ok && (refr[in_id] == '0);
  assign scan_eligible = refr[idx] == '0;

  // A refractory neuron burns one count per sweep instead of being evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) refr[i] <= '0;
    end else if (state == SCAN) begin
      if (refr[idx] != '0) refr[idx] <= refr[idx] - REFRACT_W'(1);
      else if (scan_gt) refr[idx] <= refract_len;
    end
  end
`else
  logic unused_refract;
  assign unused_refract = ^refract_len;
  assign weight_ok      = id_ok;
  assign scan_eligible  = 1'b1;
`endif

  lif_fp_update u_fp (
    .acc_v     (v_mem[in_id]),
    .acc_w     (in_weight),
    .scan_v    (v_mem[idx]),
    .scan_vth  (vth_r),
    .acc_sum   (acc_sum),
    .scan_diff (scan_diff),
    .scan_gt   (scan_gt)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (timestep_end) state_next = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (fire) state_next = EMIT;
        else if (last_idx) state_next = DONE;
      end
      EMIT: begin
        busy = 1'b1;
        if (spike_ready) state_next = last_idx ? DONE : SCAN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Single-cycle read-modify-write: the read is combinational, so back-to-back hits see the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACCUM;
      idx         <= '0;
      spike_valid <= 1'b0;
      spike_id    <= '0;
      vth_r       <= LIF_DEFAULT_VTH;
      for (int i = 0; i < NUM_NEURONS; i++) v_mem[i] <= FP_ZERO;
    end else begin
      state <= state_next;
      if (accept && weight_ok) v_mem[in_id] <= acc_sum;
      if (state == ACCUM && timestep_end) vth_r <= v_threshold;
      case (state)
        SCAN: begin
          if (fire) begin
            v_mem[idx]  <= (RESET_MODE != 0) ? FP_ZERO : scan_diff;
            spike_valid <= 1'b1;
            spike_id    <= idx;
          end else begin
            idx <= last_idx ? '0 : idx + ID_W'(1);
          end
        end
        EMIT: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            idx         <= last_idx ? '0 : idx + ID_W'(1);
          end
        end
        DONE:    idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array_engine.sv
// tb/tb_lif_neuron_array_engine.sv - self-checking bench for lif_neuron_array_engine
module tb_lif_neuron_array_engine;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        timestep_end = 1'b0;
  logic        spike_ready = 1'b1;
  logic [3:0]  in_id = 4'd0;
  logic [31:0] in_weight = 32'd0;
  logic [31:0] v_threshold = 32'h4237851f;
  logic [3:0]  refract_len = 4'd0;
  logic        in_ready, spike_valid, busy, done;
  logic [3:0]  spike_id;
  logic        rm_in_ready, rm_spike_valid, rm_busy, rm_done;
  logic [3:0]  rm_spike_id;

  int checks = 0;
  int failures = 0;
  int got_ids[$];
  int sweep_lat;
  bit busy_ok;

  always #5 clk = ~clk;

  lif_neuron_array_engine #(.NUM_NEURONS(16), .ID_W(4), .RESET_MODE(0), .REFRACT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
    .in_weight(in_weight), .timestep_end(timestep_end), .v_threshold(v_threshold),
    .refract_len(refract_len), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_id(spike_id), .busy(busy), .done(done)
  );

  lif_neuron_array_engine #(.NUM_NEURONS(16), .ID_W(4), .RESET_MODE(1), .REFRACT_W(4)) u_rm1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rm_in_ready), .in_id(in_id),
    .in_weight(in_weight), .timestep_end(timestep_end), .v_threshold(v_threshold),
    .refract_len(refract_len), .spike_valid(rm_spike_valid), .spike_ready(spike_ready),
    .spike_id(rm_spike_id), .busy(rm_busy), .done(rm_done)
  );

  typedef struct {
    int          id;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] vth;
    bit          fires;
    logic [31:0] exp_v;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_ulp(input string name, input logic [31:0] act, input logic [31:0] exp);
    int diff;
    checks++;
    diff = int'(act) - int'(exp);
    if (act[31] != exp[31] || diff > 1 || diff < -1) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (+-1ulp)", name, act, exp);
    end
  endtask

  // Exact fp32 encoding of a small integer (|x| < 2^23).
  function automatic logic [31:0] int_to_fp(input int x);
    int a, p;
    if (x == 0) return 32'h0;
    a = (x < 0) ? -x : x;
    p = $clog2(a + 1) - 1;
    return {x < 0, 8'(127 + p), 23'((a << (23 - p)) & 32'h7fffff)};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    timestep_end = 1'b0;
    spike_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_event(input int id, input logic [31:0] w);
    in_valid = 1'b1;
    in_id = 4'(id);
    in_weight = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Pulses timestep_end (with any in_valid already set up), services spikes with
  // `stall` cycles of spike_ready low each, and records ids and the done latency.
  task automatic sweep(input int stall);
    int cyc, held, first_id;
    got_ids = {};
    busy_ok = 1'b1;
    held = 0;
    first_id = 0;
    cyc = 0;
    spike_ready = (stall == 0);
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    in_valid = 1'b0;
    while (!done && cyc < 400) begin
      if (!busy) busy_ok = 1'b0;
      if (spike_valid) begin
        if (held == 0) first_id = int'(spike_id);
        else begin
          chk("stall_id_stable", {28'd0, spike_id}, 32'(first_id));
        end
        if (held >= stall) begin
          spike_ready = 1'b1;
          got_ids.push_back(int'(spike_id));
          held = 0;
        end else begin
          spike_ready = 1'b0;
          held++;
        end
      end else begin
        spike_ready = (stall == 0);
      end
      tick();
      cyc++;
    end
    if (cyc >= 400) chk("sweep_timeout", 32'(cyc), 32'd0);
    sweep_lat = cyc + 1;
    spike_ready = 1'b1;
    tick();
  endtask

  initial begin
    int mv[N];
    int exp_q[$];
    int vth, n, id, w;
    bit seen;

    vecs[0] = '{3, 32'h41F00000, 32'h41F00000, 32'h4237851f, 1'b1, 32'h4161EB85};
    vecs[1] = '{7, 32'h41200000, 32'h40A00000, 32'h41700000, 1'b0, 32'h41700000};
    vecs[2] = '{15, 32'h41A00000, 32'h41F00000, 32'h4237851f, 1'b1, 32'h4083D708};
    vecs[3] = '{9, 32'hC0400000, 32'h3F800000, 32'h4237851f, 1'b0, 32'hC0000000};

    do_reset();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_spike_valid", {31'd0, spike_valid}, 32'd0);
    chk("rst_spike_id", {28'd0, spike_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      v_threshold = vecs[t].vth;
      send_event(vecs[t].id, vecs[t].w_a);
      send_event(vecs[t].id, vecs[t].w_b);
      sweep(0);
      chk("vec_nspikes", 32'(got_ids.size()), vecs[t].fires ? 32'd1 : 32'd0);
      if (vecs[t].fires && got_ids.size() > 0) chk("vec_spike_id", 32'(got_ids[0]), 32'(vecs[t].id));
      chk_ulp("vec_v", dut.v_mem[vecs[t].id], vecs[t].exp_v);
      chk("vec_v_rm1", u_rm1.v_mem[vecs[t].id], vecs[t].fires ? 32'h0 : vecs[t].exp_v);
    end

    // Three firing neurons, each spike stalled for 4 cycles.
    do_reset();
    v_threshold = 32'h4237851f;
    send_event(1, 32'h42480000);
    send_event(5, 32'h42480000);
    send_event(9, 32'h42480000);
    sweep(4);
    chk("stall_nspikes", 32'(got_ids.size()), 32'd3);
    if (got_ids.size() == 3) begin
      chk("stall_order0", 32'(got_ids[0]), 32'd1);
      chk("stall_order1", 32'(got_ids[1]), 32'd5);
      chk("stall_order2", 32'(got_ids[2]), 32'd9);
    end

    // Weight arriving in the same cycle as timestep_end belongs to this sweep.
    do_reset();
    in_valid = 1'b1;
    in_id = 4'd0;
    in_weight = 32'h42480000;
    sweep(0);
    chk("same_cycle_nspikes", 32'(got_ids.size()), 32'd1);
    if (got_ids.size() > 0) chk("same_cycle_id", 32'(got_ids[0]), 32'd0);

    // Idle sweep latency.
    do_reset();
    sweep(0);
    chk("idle_latency", 32'(sweep_lat), 32'd17);
    chk("idle_nspikes", 32'(got_ids.size()), 32'd0);
    chk("idle_busy", {31'd0, busy_ok}, 32'd1);
    chk("idle_back_to_accum", {31'd0, in_ready}, 32'd1);

    // Reset while a spike is stalled in EMIT.
    do_reset();
    send_event(4, 32'h42480000);
    spike_ready = 1'b0;
    timestep_end = 1'b1;
    tick();
    timestep_end = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (spike_valid) seen = 1'b1;
      else tick();
    end
    chk("emit_reached", {31'd0, seen}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("emit_rst_valid", {31'd0, spike_valid}, 32'd0);
    chk("emit_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    spike_ready = 1'b1;
    for (int i = 0; i < N; i++) chk("emit_rst_v", dut.v_mem[i], 32'h0);

    // Randomized timesteps against an integer-valued model of the potentials.
    do_reset();
    for (int i = 0; i < N; i++) mv[i] = 0;
    for (int ts = 0; ts < 12; ts++) begin
      vth = int'($urandom_range(60, 20));
      n = int'($urandom_range(8, 0));
      for (int e = 0; e < n; e++) begin
        id = int'($urandom_range(15, 0));
        w = int'($urandom_range(50, 0)) - 10;
        send_event(id, int_to_fp(w));
        mv[id] += w;
      end
      v_threshold = int_to_fp(vth);
      exp_q = {};
      for (int i = 0; i < N; i++) begin
        if (mv[i] > vth) begin
          exp_q.push_back(i);
          mv[i] -= vth;
        end
      end
      sweep(int'($urandom_range(2, 0)));
      chk("rand_nspikes", 32'(got_ids.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_ids.size(); k++)
        chk("rand_spike_id", 32'(got_ids[k]), 32'(exp_q[k]));
      for (int i = 0; i < N; i++) chk("rand_v", dut.v_mem[i], int_to_fp(mv[i]));
    end

`ifdef LIF_REFRACTORY_EN
    do_reset();
    refract_len = 4'd2;
    v_threshold = 32'h4237851f;
    for (int ts = 0; ts < 4; ts++) begin
      send_event(2, 32'h42480000);
      sweep(0);
      chk("refr_nspikes", 32'(got_ids.size()), (ts == 0 || ts == 3) ? 32'd1 : 32'd0);
    end
    refract_len = 4'd0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
